mem_word_ctrl: RTL

Word-access sequencer between the 16-bit core and the byte-wide memory (8-bit data, 16-bit address, synchronous one-cycle read latency). Turns one 16-bit read or write request into two consecutive byte accesses, little-endian, and returns the assembled word with a single-cycle completion strobe. Sits directly upstream of the memory and drives all of its read/write/address/data inputs.

---
 rtl/mem_word_ctrl.sv | 95 +++++++++
 1 files changed

// File: rtl/mem_word_ctrl.sv
// mem_word_ctrl: splits one 16-bit word request into two little-endian byte
// accesses on a byte-wide memory with one-cycle read latency.
//   mwc_clk/mwc_rst_n          clock, async active-low reset
//   mwc_req/we/addr/wdata      word request, sampled when mwc_busy=0
//   mwc_busy/done/rdata/err    status, completion pulse, last read word, misalignment
//   mwc_mem_*                  byte memory address/data/enables and read data
// Optional: define MWC_ALIGN_CHECK_EN to reject odd addresses with an err pulse.
module mem_word_ctrl #(
    parameter int ADDR_W = 16
) (
    input  logic              mwc_clk,
    input  logic              mwc_rst_n,
    input  logic              mwc_req,
    input  logic              mwc_we,
    input  logic [ADDR_W-1:0] mwc_addr,
    input  logic [15:0]       mwc_wdata,
    output logic              mwc_busy,
    output logic              mwc_done,
    output logic [15:0]       mwc_rdata,
    output logic              mwc_err,
    output logic [ADDR_W-1:0] mwc_mem_addr,
    output logic [7:0]        mwc_mem_wdata,
    output logic              mwc_mem_rd_en,
    output logic              mwc_mem_wr_en,
    input  logic [7:0]        mwc_mem_rdata
);
    typedef enum logic [1:0] {IDLE, LO, HI, WAIT} state_t;
    state_t      state;
    logic        we_q;
    logic        mis_q;
    logic        mis;
    logic [7:0]  wdata_hi;
    logic [7:0]  lo_q;
`ifdef MWC_ALIGN_CHECK_EN
    assign mis = mwc_addr[0];
`else
    assign mis = 1'b0;
`endif
    always_ff @(posedge mwc_clk or negedge mwc_rst_n) begin
        if (!mwc_rst_n) begin
            state         <= IDLE;
            we_q          <= 1'b0;
            mis_q         <= 1'b0;
            wdata_hi      <= 8'h00;
            lo_q          <= 8'h00;
            mwc_busy      <= 1'b0;
            mwc_done      <= 1'b0;
            mwc_err       <= 1'b0;
            mwc_rdata     <= 16'h0000;
            mwc_mem_addr  <= '0;
            mwc_mem_wdata <= 8'h00;
            mwc_mem_rd_en <= 1'b0;
            mwc_mem_wr_en <= 1'b0;
        end else begin
            mwc_done <= 1'b0;
            mwc_err  <= 1'b0;
            case (state)
                IDLE: if (mwc_req) begin
                    we_q     <= mwc_we;
                    mis_q    <= mis;
                    wdata_hi <= mwc_wdata[15:8];
                    mwc_busy <= 1'b1;
                    // a rejected odd access skips straight to completion
                    if (mis) state <= WAIT;
                    else begin
                        state         <= LO;
                        mwc_mem_addr  <= mwc_addr;
                        mwc_mem_wdata <= mwc_wdata[7:0];
                        mwc_mem_rd_en <= !mwc_we;
                        mwc_mem_wr_en <= mwc_we;
                    end
                end
                LO: begin
                    state         <= HI;
                    mwc_mem_addr  <= mwc_mem_addr + ADDR_W'(1);
                    mwc_mem_wdata <= wdata_hi;
                end
                HI: begin
                    state         <= WAIT;
                    mwc_mem_rd_en <= 1'b0;
                    mwc_mem_wr_en <= 1'b0;
                    if (!we_q) lo_q <= mwc_mem_rdata;
                end
                WAIT: begin
                    state    <= IDLE;
                    mwc_busy <= 1'b0;
                    mwc_done <= 1'b1;
                    mwc_err  <= mis_q;
                    if (!we_q && !mis_q) mwc_rdata <= {mwc_mem_rdata, lo_q};
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
